// File: rtl/fpa_arb_pkg.sv
// Shared definitions for the floating-point adder share arbiter.
// Contents:
//   arb_state_t  - FSM state encoding
//   DEF_*        - default WIDTH, NUM_REQ and TIMEOUT values
//   next_rr_idx  - circular successor of a requester index
package fpa_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 255;

    // Index following idx, wrapping to 0 after n-1.
    function automatic int unsigned next_rr_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fpa_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector
//   ptr     - index of the last served requester; search starts after it
//   win     - one-hot winner (all zero when no request)
//   win_idx - binary index of the winner (0 when no request)
module fpa_rr_pick
    import fpa_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = int'(ptr);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = next_rr_idx(cand, NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fpa_share_arbiter.sv
// Round-robin scheduler sharing one floating-point adder among NUM_REQ
// requesters, with a watchdog that aborts transactions whose adder never
// returns done.
// Ports:
//   CLK, rst              - clock (rising edge), async active-high reset
//   req                   - per-requester request level, sampled in IDLE only
//   opA, opB              - packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt                   - one-hot grant, held from grant through RESP
//   res, res_valid        - result and one-cycle valid on the served bit
//   res_err               - flags a watchdog abort (res is 0 then)
//   busy                  - high outside IDLE
//   fpa_start, fpa_A/B    - adder start pulse and latched operands
//   fpa_done, fpa_result  - adder done level and result
module fpa_share_arbiter
    import fpa_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] opA,
    input  logic [NUM_REQ*WIDTH-1:0] opB,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         res,
    output logic [NUM_REQ-1:0]       res_valid,
    output logic                     res_err,
    output logic                     busy,
    output logic                     fpa_start,
    output logic [WIDTH-1:0]         fpa_A,
    output logic [WIDTH-1:0]         fpa_B,
    input  logic                     fpa_done,
    input  logic [WIDTH-1:0]         fpa_result
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WD_REQ = $clog2(TIMEOUT + 1);
    localparam int WD_W   = (WD_REQ > 8) ? WD_REQ : 8;
    // The counter value seen on the edge that makes it reach TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t         state, next_state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic [WD_W-1:0]    wd;
    logic               timeout_hit;

    fpa_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                // A busy adder (left running by an abort) blocks new grants.
                if ((|req) && fpa_done) next_state = ST_START;
            end
            ST_START: next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!fpa_done) begin
                    next_state = ST_WAIT_DONE;
                end else if (wd == WD_LAST) begin
                    next_state  = ST_RESP;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                // A done on the final watchdog cycle still counts as success.
                if (fpa_done) begin
                    next_state = ST_RESP;
                end else if (wd == WD_LAST) begin
                    next_state  = ST_RESP;
                    timeout_hit = 1'b1;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= IDX_W'(NUM_REQ - 1);
            fpa_A   <= '0;
            fpa_B   <= '0;
            res     <= '0;
            res_err <= 1'b0;
            wd      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (next_state == ST_START) begin
                        gnt     <= win;
                        gnt_idx <= win_idx;
                        fpa_A   <= opA[int'(win_idx)*WIDTH +: WIDTH];
                        fpa_B   <= opB[int'(win_idx)*WIDTH +: WIDTH];
                    end
                end
                ST_START: wd <= '0;
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    if (next_state == ST_RESP) begin
                        ptr     <= gnt_idx;
                        res     <= timeout_hit ? '0 : fpa_result;
                        res_err <= timeout_hit;
                    end
                end
                ST_RESP: begin
                    gnt     <= '0;
                    res_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fpa_start = (state == ST_START);
    assign res_valid = (state == ST_RESP) ? gnt : '0;

endmodule

// File: tb/tb_fpa_share_arbiter.sv
// Directed bench for fpa_share_arbiter with a behavioural adder model
// (10-cycle latency, optional never-done mode) and TIMEOUT=20.
module tb_fpa_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 10;
    localparam int TO  = 20;

    logic           CLK = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] opA = '0;
    logic [N*W-1:0] opB = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   res;
    logic [N-1:0]   res_valid;
    logic           res_err;
    logic           busy;
    logic           fpa_start;
    logic [W-1:0]   fpa_A;
    logic [W-1:0]   fpa_B;
    logic           fpa_done;
    logic [W-1:0]   fpa_result;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic never_done = 1'b0;
    int   acnt;
    logic [W-1:0] pend;

    fpa_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .req        (req),
        .opA        (opA),
        .opB        (opB),
        .gnt        (gnt),
        .res        (res),
        .res_valid  (res_valid),
        .res_err    (res_err),
        .busy       (busy),
        .fpa_start  (fpa_start),
        .fpa_A      (fpa_A),
        .fpa_B      (fpa_B),
        .fpa_done   (fpa_done),
        .fpa_result (fpa_result)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Hand-computed sums for the operand pairs used below.
    function automatic logic [W-1:0] fadd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40100000}: return 32'h40700000; // 1.5+2.25
            {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
            {32'h3F000000, 32'h3F000000}: return 32'h3F800000; // 0.5+0.5
            default:                      return 32'hBAD0BAD0;
        endcase
    endfunction

    // Adder model: done drops on start, rises LAT+1 edges later with the sum.
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            fpa_done   <= 1'b1;
            acnt       <= 0;
            fpa_result <= '0;
            pend       <= '0;
        end else if (fpa_start) begin
            fpa_done <= 1'b0;
            acnt     <= LAT;
            pend     <= fadd_ref(fpa_A, fpa_B);
        end else if (!fpa_done && !never_done) begin
            if (acnt > 0) begin
                acnt <= acnt - 1;
            end else begin
                fpa_done   <= 1'b1;
                fpa_result <= pend;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (gnt != '0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("gnt_wait_expired", 0, 1);
    endtask

    task automatic wait_rv(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (res_valid != '0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("rv_wait_expired", 0, 1);
    endtask

    task automatic wait_adder_busy(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!fpa_done) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) check("done_low_wait_expired", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int t0, t1, rv_seen;
        logic [W-1:0] rr_exp [5];
        rr_exp = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h3F800000, 32'h40000000};

        // Reset state
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res", res, 0);
        check("rst_res_err", 32'(res_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(fpa_start), 0);
        check("rst_fpa_A", fpa_A, 0);
        check("rst_fpa_B", fpa_B, 0);

        // Single request, 1.5 + 2.25
        opA[0*W +: W] = 32'h3FC00000;
        opB[0*W +: W] = 32'h40100000;
        req = 4'b0001;
        wait_gnt(10, t0);
        req = '0;
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_start", 32'(fpa_start), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_fpa_A", fpa_A, 32'h3FC00000);
        check("t1_fpa_B", fpa_B, 32'h40100000);
        @(negedge CLK);
        check("t1_start_pulse", 32'(fpa_start), 0);
        wait_rv(50, t1);
        check("t1_latency", 32'(t1 - t0), 13);
        check("t1_res", res, 32'h40700000);
        check("t1_rv", 32'(res_valid), 32'h1);
        check("t1_err", 32'(res_err), 0);
        check("t1_gnt_resp", 32'(gnt), 32'h1);
        @(negedge CLK);
        check("t1_gnt_clear", 32'(gnt), 0);
        check("t1_rv_pulse", 32'(res_valid), 0);
        check("t1_idle", 32'(busy), 0);

        // All four requesting: order 0,1,2,3,0 from a fresh pointer
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        opA[0*W +: W] = 32'h3F800000; opB[0*W +: W] = 32'h3F800000;
        opA[1*W +: W] = 32'h40000000; opB[1*W +: W] = 32'h40000000;
        opA[2*W +: W] = 32'h3F800000; opB[2*W +: W] = 32'h40000000;
        opA[3*W +: W] = 32'h3F000000; opB[3*W +: W] = 32'h3F000000;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rv(50, t1);
            if (k == 4) req = '0;
            check($sformatf("rr%0d_rv", k), 32'(res_valid), 32'(1 << (k % N)));
            check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << (k % N)));
            check($sformatf("rr%0d_res", k), res, rr_exp[k]);
        end
        @(negedge CLK);
        check("rr_idle", 32'(busy), 0);

        // req[2] dropped mid-transaction; operands changed after grant
        req = 4'b0100;
        wait_gnt(10, t0);
        check("t3_gnt", 32'(gnt), 32'h4);
        opA[2*W +: W] = 32'h40400000;
        opB[2*W +: W] = 32'h3F800000;
        wait_adder_busy(10);
        @(negedge CLK);
        req = '0;
        check("t3_hold_A", fpa_A, 32'h3F800000);
        check("t3_hold_B", fpa_B, 32'h40000000);
        wait_rv(50, t1);
        check("t3_rv", 32'(res_valid), 32'h4);
        check("t3_gnt_resp", 32'(gnt), 32'h4);
        check("t3_res", res, 32'h40400000);
        @(negedge CLK);
        check("t3_gnt_clear", 32'(gnt), 0);
        opA[2*W +: W] = 32'h3F800000;
        opB[2*W +: W] = 32'h40000000;

        // Reset during WAIT_DONE, then requester 0 wins over 3
        req = 4'b0010;
        wait_gnt(10, t0);
        check("t5_gnt", 32'(gnt), 32'h2);
        wait_adder_busy(10);
        repeat (2) @(negedge CLK);
        check("t5_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("t5_async_gnt", 32'(gnt), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_start", 32'(fpa_start), 0);
        check("t5_async_rv", 32'(res_valid), 0);
        check("t5_async_res", res, 0);
        check("t5_async_err", 32'(res_err), 0);
        check("t5_async_A", fpa_A, 0);
        check("t5_async_B", fpa_B, 0);
        @(negedge CLK);
        rst = 1'b0;
        req = 4'b1001;
        rv_seen = 0;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (res_valid != '0) rv_seen++;
            if (gnt != '0) begin
                t0 = cyc;
                break;
            end
        end
        check("t5_regrant_seen", 32'(t0 >= 0), 1);
        check("t5_no_rv", 32'(rv_seen), 0);
        check("t5_gnt_after_rst", 32'(gnt), 32'h1);
        req = '0;
        wait_rv(50, t1);
        check("t5_rv", 32'(res_valid), 32'h1);
        check("t5_res", res, 32'h40000000);

        // Watchdog: adder never completes
        never_done = 1'b1;
        req = 4'b0001;
        wait_gnt(10, t0);
        wait_rv(60, t1);
        check("t4_latency", 32'(t1 - (t0 + 1)), TO);
        check("t4_err", 32'(res_err), 1);
        check("t4_res", res, 0);
        check("t4_rv", 32'(res_valid), 32'h1);
        @(negedge CLK);
        check("t4_err_pulse", 32'(res_err), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("t4_stay_idle%0d", i), {30'd0, busy, |gnt}, 0);
        end
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpa_share_arbiter.md
# fpa_share_arbiter

Round-robin scheduler that shares one floating-point adder among NUM_REQ requesters. Each requester presents two IEEE-754 single-precision operands and holds a request. The arbiter grants one requester, latches its operands, and sequences the adder's start/done handshake. It then returns the sum to the granted requester with a one-cycle valid pulse. A watchdog aborts a transaction if the adder does not return done in time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- TIMEOUT, 255, max cycles allowed in WAIT_BUSY+WAIT_DONE before abort
- CLK  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req  in  NUM_REQ  per-requester request level
- opA  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- opB  in  NUM_REQ*WIDTH  operand B, same packing
- gnt  out  NUM_REQ  one-hot grant, held from grant until the response cycle inclusive
- res  out  WIDTH  result, valid only with res_valid
- res_valid  out  NUM_REQ  one-cycle pulse on the bit of the served requester
- res_err  out  1  pulses with res_valid when the transaction timed out; res=0 then
- busy  out  1  high in every state except IDLE
- fpa_start  out  1  adder start
- fpa_A, fpa_B  out  WIDTH  adder operands, stable from START through WAIT_DONE
- fpa_done  in  1  adder done (high while adder idle)
- fpa_result  in  WIDTH  adder result, valid when fpa_done rises

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req bit is set and fpa_done=1, pick a winner by round-robin.
  - Register gnt and latch opA/opB of the winner into fpa_A/fpa_B.
  - Go to START.
  - If fpa_done=0 (adder still busy after an abort), stay in IDLE.
- Round-robin: priority starts at the index after the last served requester. The pointer resets to NUM_REQ-1, so requester 0 has priority first. The pointer updates on entry to RESP.
- START: fpa_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: fpa_start=0; wait for fpa_done=0, then go to WAIT_DONE.
- WAIT_DONE: wait for fpa_done=1. On that cycle, latch fpa_result into res and go to RESP.
- RESP: res_valid[granted]=1 for one cycle, gnt still asserted, then go to IDLE with gnt cleared.
- Watchdog: an 8-bit or larger counter clears in START and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT: go to RESP with res_err=1 and res=0.
- req dropped mid-transaction: ignored. The transaction completes and res_valid still pulses.
- req inputs are sampled only in IDLE. Operand changes after the grant have no effect.

## Timing
- Reset values: state IDLE, gnt=0, res_valid=0, res=0, res_err=0, busy=0, fpa_start=0, fpa_A=fpa_B=0, watchdog=0, pointer=NUM_REQ-1.
- Reset mid-transaction aborts immediately with no response. The adder is reset by the same rst.
- Latency: req seen in IDLE at edge k gives:
  - gnt and fpa_start high after edge k;
  - WAIT_BUSY after k+1;
  - res_valid one cycle after fpa_done returns high.
- Total latency is adder latency + 3 cycles.
- Back-to-back: RESP is followed by IDLE, so the minimum spacing between grants is one idle cycle.
- Simultaneous requests: exactly one grant per transaction. Requester i waits at most NUM_REQ-1 transactions.

## Structure
- Package fpa_arb_pkg holds:
  - the state enum;
  - default WIDTH, NUM_REQ and TIMEOUT constants;
  - a function for the next round-robin index.
- Sub-module fpa_rr_pick: combinational round-robin picker.
  - Inputs: req and pointer.
  - Outputs: one-hot winner and its index.
- The top level contains the FSM, operand/result registers and watchdog.

## Test plan
- Single request, adder model with 10-cycle latency.
  - Stimulus: req[0]=1, opA=0x3FC00000 (1.5), opB=0x40100000 (2.25).
  - Expect: fpa_start pulse; res=0x40700000 (3.75); res_valid=0001 13 cycles after grant.
- All four requesters held high continuously.
  - Expect grant order 0,1,2,3,0; each res_valid pulses on the matching bit.
- req[2] drops during WAIT_DONE.
  - Expect the transaction to complete with res_valid=0100 and gnt=0100 cleared after RESP.
- Adder model never raises done, TIMEOUT=20.
  - Expect res_err=1, res=0 and res_valid pulse 20 cycles after WAIT_BUSY entry.
  - Then the arbiter stays in IDLE while fpa_done=0.
- rst asserted in WAIT_DONE.
  - Expect all outputs to return to their reset values asynchronously.
  - Expect no res_valid, and the next grant to go to requester 0.
- Operands change on opA/opB after the grant.
  - Expect fpa_A/fpa_B to hold the values latched at the grant.
